// File: rtl/control_sequencer_if.sv
// Control sequencer <-> memory/datapath signal bundle.
//   start, mem_ready, ir : inputs to the sequencer
//   PCout..MDRout        : bus source selects
//   MARin..LOin          : register load enables
//   IncPC, Read          : PC increment via ALU, memory read request
//   Rin, Rout            : one-hot general register load / drive
//   alu_op, busy, done, illegal : operation code and status
interface control_sequencer_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned OPCODE_W = 5
);
  logic                start;
  logic                mem_ready;
  logic [DATA_W-1:0]   ir;
  logic                PCout, Zlowout, Zhighout, MDRout;
  logic                MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin;
  logic                IncPC, Read;
  logic [NUM_REGS-1:0] Rin, Rout;
  logic [OPCODE_W-1:0] alu_op;
  logic                busy, done, illegal;

  modport master (
    input  start, mem_ready, ir,
    output PCout, Zlowout, Zhighout, MDRout,
    output MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin,
    output IncPC, Read, Rin, Rout, alu_op, busy, done, illegal
  );

  modport slave (
    output start, mem_ready, ir,
    input  PCout, Zlowout, Zhighout, MDRout,
    input  MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin,
    input  IncPC, Read, Rin, Rout, alu_op, busy, done, illegal
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control unit for a 3-register ALU datapath.
// Ports:
//   clk  - rising-edge clock
//   clr  - asynchronous active-low reset (state IDLE, all strobes low)
//   bus  - control_sequencer_if.master: start/mem_ready/ir in, strobes out
// Outputs are Moore-decoded from the state register; instruction fields used
// after T3 come from a copy latched at T3 so later ir changes are ignored.
module control_sequencer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_REGS  = 16,
  parameter int unsigned REG_SEL_W = 4,
  parameter int unsigned OPCODE_W  = 5,
  parameter int unsigned FREE_RUN  = 0
) (
  input  logic                clk,
  input  logic                clr,
  control_sequencer_if.master bus
);

  localparam int unsigned RA_MSB = DATA_W - OPCODE_W - 1;
  localparam int unsigned RB_MSB = RA_MSB - REG_SEL_W;
  localparam int unsigned RC_MSB = RB_MSB - REG_SEL_W;
  localparam int unsigned RC_LSB = RC_MSB - REG_SEL_W + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_TW, S_T2, S_T3, S_T4, S_T5, S_T6, S_TRAP, S_END
  } state_t;

  state_t state_q, state_d;

  logic [OPCODE_W-1:0]  op_c, op_q;
  logic [REG_SEL_W-1:0] ra_c, rb_c, rc_c, ra_q, rc_q;
  logic                 muldiv_c, muldiv_q, legal_c;
  logic                 unused_ir;

  function automatic logic reg_ok(input logic [REG_SEL_W-1:0] sel);
    return {1'b0, sel} < (REG_SEL_W+1)'(NUM_REGS);
  endfunction

  function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_SEL_W-1:0] sel);
    return NUM_REGS'(1) << sel;
  endfunction

  // Instruction field extraction and legality check (used live only in T3)
  assign op_c      = bus.ir[DATA_W-1 -: OPCODE_W];
  assign ra_c      = bus.ir[RA_MSB -: REG_SEL_W];
  assign rb_c      = bus.ir[RB_MSB -: REG_SEL_W];
  assign rc_c      = bus.ir[RC_MSB -: REG_SEL_W];
  assign unused_ir = ^bus.ir[RC_LSB-1:0];
  assign muldiv_c  = (op_c == OPCODE_W'(15)) || (op_c == OPCODE_W'(16));
  // MUL/DIV write LO/HI, so ra is not a used field for them
  assign legal_c   = muldiv_c ? (reg_ok(rb_c) && reg_ok(rc_c))
                              : ((op_c >= OPCODE_W'(3)) && (op_c <= OPCODE_W'(10)) &&
                                 reg_ok(ra_c) && reg_ok(rb_c) && reg_ok(rc_c));

  // State register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Decode latched at T3 for the execute states
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      op_q     <= '0;
      ra_q     <= '0;
      rc_q     <= '0;
      muldiv_q <= 1'b0;
    end else if (state_q == S_T3) begin
      op_q     <= op_c;
      ra_q     <= ra_c;
      rc_q     <= rc_c;
      muldiv_q <= muldiv_c;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    state_d      = state_q;
    bus.PCout    = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.Zhighout = 1'b0;
    bus.MDRout   = 1'b0;
    bus.MARin    = 1'b0;
    bus.PCin     = 1'b0;
    bus.MDRin    = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.Zin      = 1'b0;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    bus.IncPC    = 1'b0;
    bus.Read     = 1'b0;
    bus.Rin      = '0;
    bus.Rout     = '0;
    bus.alu_op   = '0;
    bus.busy     = (state_q != S_IDLE);
    bus.done     = 1'b0;
    bus.illegal  = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_T0;
      S_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
        state_d   = S_T1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
        state_d     = bus.mem_ready ? S_T2 : S_TW;
      end
      // Wait state keeps the read open without reloading PC
      S_TW: begin
        bus.Read  = 1'b1;
        bus.MDRin = 1'b1;
        state_d   = bus.mem_ready ? S_T2 : S_TW;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        state_d    = S_T3;
      end
      S_T3: begin
        bus.Rout = onehot(rb_c);
        bus.Yin  = 1'b1;
        state_d  = legal_c ? S_T4 : S_TRAP;
      end
      S_T4: begin
        bus.Rout   = onehot(rc_q);
        bus.Zin    = 1'b1;
        bus.alu_op = op_q;
        state_d    = S_T5;
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        if (muldiv_q) begin
          bus.LOin = 1'b1;
          state_d  = S_T6;
        end else begin
          bus.Rin  = onehot(ra_q);
          bus.done = 1'b1;
          state_d  = S_END;
        end
      end
      S_T6: begin
        bus.Zhighout = 1'b1;
        bus.HIin     = 1'b1;
        bus.done     = 1'b1;
        state_d      = S_END;
      end
      S_TRAP: begin
        bus.illegal = 1'b1;
        state_d     = S_END;
      end
      S_END:   state_d = (FREE_RUN != 0) ? S_T0 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule
